// File: rtl/sar_ctrl_pkg.sv
// Shared types and constants for the SAR control stage.
// Defining SAR_CTRL_MAJ_EN selects three comparator decisions per bit (majority vote).
package sar_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_STROBE = 2'd2;
    localparam state_t ST_DECIDE = 2'd3;

`ifdef SAR_CTRL_MAJ_EN
    localparam int unsigned DECISIONS_PER_BIT = 3;
`else
    localparam int unsigned DECISIONS_PER_BIT = 1;
`endif

    // Edges from the accepting edge of start to the edge that raises done.
    function automatic int unsigned conv_latency(input int unsigned n_bits,
                                                 input int unsigned settle_cycles);
        return n_bits * (settle_cycles + 2 * DECISIONS_PER_BIT);
    endfunction

endpackage

// File: rtl/sar_ctrl_vote.sv
// Majority-of-three accumulator for repeated comparator decisions on one bit.
// Only instantiated when SAR_CTRL_MAJ_EN is defined.
module sar_ctrl_vote (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic acc,
    input  logic din,
    output logic maj
);

    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 2'd0;
        end else if (acc && din && (cnt_q != 2'd3)) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Includes the sample being accumulated this cycle so the final vote needs no extra cycle.
    always_comb begin
        maj = (cnt_q >= 2'd2) || ((cnt_q == 2'd1) && acc && din);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: strobes the comparator and resolves an N_BITS code MSB-first.
// Optional SAR_CTRL_MAJ_EN takes the majority of three comparator decisions per bit.
module sar_ctrl
    import sar_ctrl_pkg::*;
#(
    parameter int unsigned N_BITS        = 8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmp_out,
    output logic              cmp_clk,
    output logic [N_BITS-1:0] dac_code,
    output logic [N_BITS-1:0] code_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       IDX_W    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(N_BITS - 1);
    localparam logic [3:0]        CNT_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [N_BITS-1:0] MSB_ONLY = {1'b1, {(N_BITS - 1){1'b0}}};

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [N_BITS-1:0]   dac_q, dac_d;
    logic [N_BITS-1:0]   code_q, code_d;
    logic                cmp_clk_q, cmp_clk_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_dec;
    logic                last_sample;

`ifdef SAR_CTRL_MAJ_EN
    logic [1:0] rep_q, rep_d;
    logic       vote_clr, vote_acc, vote_maj;

    sar_ctrl_vote u_vote (
        .clk (clk),
        .rst (rst),
        .clr (vote_clr),
        .acc (vote_acc),
        .din (cmp_out),
        .maj (vote_maj)
    );

    assign bit_dec     = vote_maj;
    assign last_sample = (rep_q == 2'(DECISIONS_PER_BIT - 1));

    always_comb begin
        rep_d    = rep_q;
        vote_acc = 1'b0;
        vote_clr = 1'b0;
        if (state_q == ST_DECIDE) begin
            vote_acc = 1'b1;
            if (last_sample) begin
                rep_d    = 2'd0;
                vote_clr = 1'b1;
            end else begin
                rep_d = rep_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_q <= 2'd0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign bit_dec     = cmp_out;
    assign last_sample = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        dac_d     = dac_q;
        code_d    = code_q;
        busy_d    = busy_q;
        cmp_clk_d = 1'b0;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dac_d   = MSB_ONLY;
                    idx_d   = IDX_MSB;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    cmp_clk_d = 1'b1;
                    state_d   = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (!last_sample) begin
                    // Re-strobe on the same trial code; cmp_clk stays low for this cycle.
                    cmp_clk_d = 1'b1;
                    state_d   = ST_STROBE;
                end else begin
                    dac_d[idx_q] = bit_dec;
                    if (idx_q != '0) begin
                        idx_d        = idx_q - 1'b1;
                        dac_d[idx_d] = 1'b1;
                        cnt_d        = CNT_INIT;
                        state_d      = ST_SETTLE;
                    end else begin
                        code_d  = dac_d;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= IDX_MSB;
            cnt_q     <= 4'd0;
            dac_q     <= '0;
            code_q    <= '0;
            cmp_clk_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            dac_q     <= dac_d;
            code_q    <= code_d;
            cmp_clk_q <= cmp_clk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign cmp_clk  = cmp_clk_q;
    assign dac_code = dac_q;
    assign code_out = code_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Self-checking bench for sar_ctrl against an ideal comparator/DAC model.
// Build with SAR_CTRL_MAJ_EN defined to exercise the majority-vote variant.
module tb_sar_ctrl;

    localparam int NB = 8;
    localparam int SC = 1;
`ifdef SAR_CTRL_MAJ_EN
    localparam int DPB = 3;
`else
    localparam int DPB = 1;
`endif
    localparam int LAT = NB * (SC + 2 * DPB);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cmp_out;
    logic          cmp_clk;
    logic [NB-1:0] dac_code;
    logic [NB-1:0] code_out;
    logic          busy;
    logic          done;

    int vin2;   // analog input in half-LSB units
    bit flip;   // inverts the comparator decision
    int n_cmp = 0;
    int n_fail = 0;

    sar_ctrl #(
        .N_BITS        (NB),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .cmp_out  (cmp_out),
        .cmp_clk  (cmp_clk),
        .dac_code (dac_code),
        .code_out (code_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    always_comb cmp_out = (vin2 > 2 * int'(dac_code)) ^ flip;

    // Ideal SAR result: number of DAC codes 1..2^NB-1 strictly below the input.
    function automatic int model_code(input int v2);
        int c = 0;
        for (int t = 1; t < (1 << NB); t++) begin
            if (v2 > 2 * t) c++;
        end
        return c;
    endfunction

    task automatic run_conv(input int v2, input int restart_at, input bit flip_first,
                            output int lat, output int pulses, output int busy_cyc,
                            output int code);
        int n;
        int flip_n;
        bit seen;
        vin2 = v2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1; lat = -1; pulses = 0; busy_cyc = 0; code = -1; seen = 0; flip_n = 0;
        while (!seen && n <= LAT + 20) begin
            if (done) begin
                seen = 1;
                lat  = n - 1;
                code = int'(code_out);
            end
            if (busy) busy_cyc++;
            if (flip && n >= flip_n + 2) flip = 1'b0;
            if (cmp_clk) begin
                pulses++;
                if (flip_first && pulses == 1) begin
                    flip   = 1'b1;
                    flip_n = n;
                end
            end
            start = (restart_at != 0 && n == restart_at);
            if (!seen) begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        flip  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; vin2 = 0; flip = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cmp_clk, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000", {cmp_clk, busy, done});
        end
        n_cmp++;
        if ({dac_code, code_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_codes: got dac=%h code=%h want 0", dac_code, code_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_conv(input string tag, input int v2);
        int lat, pulses, bc, code;
        run_conv(v2, 0, 1'b0, lat, pulses, bc, code);
        n_cmp++;
        if (code !== model_code(v2)) begin
            n_fail++;
            $display("FAIL %s code: got %0h want %0h", tag, code, model_code(v2));
        end
        n_cmp++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", tag, lat, LAT);
        end
        n_cmp++;
        if (pulses !== NB * DPB) begin
            n_fail++;
            $display("FAIL %s strobes: got %0d want %0d", tag, pulses, NB * DPB);
        end
        n_cmp++;
        if (bc !== LAT) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d want %0d", tag, bc, LAT);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: got %b want 0", tag, done);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 5; i++) begin
            test_conv("random", int'($urandom_range(0, 600)));
        end
    endtask

    task automatic test_start_while_busy;
        int lat, pulses, bc, code, extra;
        run_conv(331, 5, 1'b0, lat, pulses, bc, code);
        n_cmp++;
        if (code !== 8'hA5 || lat !== LAT) begin
            n_fail++;
            $display("FAIL busy_start: got code=%0h lat=%0d want a5/%0d", code, lat, LAT);
        end
        extra = 0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (done) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL busy_start_extra_done: got %0d want 0", extra);
        end
    endtask

    task automatic test_mid_reset;
        int lat, pulses, bc, code;
        vin2 = 331;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({cmp_clk, busy, done, dac_code, code_out} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got clk=%b busy=%b done=%b dac=%h code=%h want all 0",
                     cmp_clk, busy, done, dac_code, code_out);
        end
        @(negedge clk);
        rst = 1'b0;
        run_conv(331, 0, 1'b0, lat, pulses, bc, code);
        n_cmp++;
        if (code !== 8'hA5) begin
            n_fail++;
            $display("FAIL mid_reset_after: got %0h want a5", code);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int n;
        vin2 = 331;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (!done && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (done !== 1'b1 || code_out !== 8'hA5) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b code=%h want 1/a5", done, code_out);
        end
        vin2 = 85;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
        end
        @(negedge clk);
        n = 1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: got busy=%b want 1", busy);
        end
        while (!done && n < LAT + 20) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        n_cmp++;
        if (n !== LAT + 1 || code_out !== 8'h2A) begin
            n_fail++;
            $display("FAIL b2b_second: got gap=%0d code=%h want %0d/2a", n, code_out, LAT + 1);
        end
        repeat (LAT + 5) @(negedge clk);
    endtask

    task automatic test_flipped_msb;
        int lat, pulses, bc, code;
        run_conv(331, 0, 1'b1, lat, pulses, bc, code);
`ifdef SAR_CTRL_MAJ_EN
        // One bad sample out of three is outvoted.
        n_cmp++;
        if (code !== 8'hA5) begin
            n_fail++;
            $display("FAIL maj_code: got %0h want a5", code);
        end
`else
        // A single wrong MSB decision leaves the lower bits to saturate.
        n_cmp++;
        if (code !== 8'h7F) begin
            n_fail++;
            $display("FAIL flip_code: got %0h want 7f", code);
        end
`endif
        n_cmp++;
        if (lat !== LAT || pulses !== NB * DPB) begin
            n_fail++;
            $display("FAIL flip_timing: got lat=%0d strobes=%0d want %0d/%0d",
                     lat, pulses, LAT, NB * DPB);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_conv("vin165p5", 331);
        test_conv("vin0", 0);
        test_conv("vin300", 600);
        test_random();
        test_start_while_busy();
        test_mid_reset();
        test_back_to_back();
        test_flipped_msb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_ctrl.md
Name: sar_ctrl

Overview:
- Successive-approximation control stage sitting directly downstream of the clocked comparator.
- Consumes the comparator's 1-bit decision and generates the comparator strobe.
- Drives the trial code to the DAC model whose real-valued output feeds the comparator's in_n.
- Resolves an N_BITS binary code MSB-first and publishes it with a one-cycle done pulse.

Parameters:
- N_BITS, 8, resolution of the conversion; legal range 2..16.
- SETTLE_CYCLES, 1, cycles dac_code is held stable before each comparator strobe; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- cmp_out  input  1  comparator decision; 1 means in_p > in_n.
- cmp_clk  output  1  comparator strobe; registered, glitch-free; the comparator latches on its rising edge.
- dac_code  output  N_BITS  trial code driven to the DAC feeding comparator in_n.
- code_out  output  N_BITS  last completed conversion result.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when code_out updates.

Behaviour:
- Reset (async assert, synchronous to clk on deassert): state=IDLE, cmp_clk=0, dac_code=0, code_out=0, busy=0, done=0, bit index=N_BITS-1, settle counter=0. cmp_clk drops immediately on rst, with no pulse stretching.
- States: IDLE, SETTLE, STROBE, DECIDE.
- IDLE:
  - If start=1: dac_code <= 1<<(N_BITS-1), idx <= N_BITS-1, busy <= 1, settle cnt <= SETTLE_CYCLES-1, go to SETTLE.
  - Otherwise hold.
- SETTLE:
  - cmp_clk=0.
  - If cnt==0, go to STROBE; else cnt--.
  - Lasts exactly SETTLE_CYCLES cycles.
- STROBE: cmp_clk <= 1 for exactly one cycle; go to DECIDE.
- DECIDE:
  - cmp_clk <= 0; sample cmp_out.
  - If cmp_out=0, clear dac_code[idx]; if cmp_out=1, keep it.
  - If idx>0: idx--, set dac_code[idx-1], cnt <= SETTLE_CYCLES-1, go to SETTLE.
  - If idx==0: code_out <= resolved code (including bit-0 decision), done <= 1, busy <= 0, go to IDLE.
- done is high for exactly one cycle. dac_code holds the final code in IDLE.
- Latency: per bit SETTLE_CYCLES+2 cycles. If start is sampled at edge k, done is high during the cycle after edge k+N_BITS*(SETTLE_CYCLES+2). With defaults this is 24 cycles.
- start while busy: ignored, with no queueing.
- start high in the cycle done is high: the FSM is already in IDLE, so the conversion is accepted normally. code_out holds the previous result until the next done.
- start held high continuously: back-to-back conversions with one IDLE cycle between them.
- cmp_out is ignored outside DECIDE.
- Reset mid-conversion: everything returns to reset values and code_out is cleared to 0. There is no partial result and no done pulse.

Optional Feature:
- Macro: SAR_CTRL_MAJ_EN.
- Defined:
  - Each bit uses three STROBE/DECIDE pairs after one SETTLE period; dac_code is constant across them.
  - The bit decision is the majority of the three cmp_out samples.
  - Per-bit latency becomes SETTLE_CYCLES+6; with defaults, start-to-done is 56 cycles.
  - cmp_clk returns low for at least one cycle between strobes.
- Undefined: single decision per bit as above; the vote logic is absent.

Decomposition:
- Package sar_ctrl_pkg:
  - State enum (IDLE, SETTLE, STROBE, DECIDE).
  - Constant DECISIONS_PER_BIT (1, or 3 under SAR_CTRL_MAJ_EN).
  - Function computing conversion latency from N_BITS and SETTLE_CYCLES, shared with the bench.
- Sub-module sar_ctrl_vote: 2-bit decision counter with clear, accumulate and majority output. Instantiated only under SAR_CTRL_MAJ_EN.

Test Plan:
- Ideal model (cmp_out = vin_lsb > dac_code), vin=165.5 LSB, N_BITS=8, SETTLE_CYCLES=1, pulse start -> code_out=0xA5, done exactly 24 cycles after start, 8 cmp_clk pulses, busy high 24 cycles.
- vin=0 -> code_out=0x00. vin=300 LSB (over range) -> code_out=0xFF. Both take 24 cycles.
- Start pulsed again at cycle 5 of a conversion -> ignored; a single done; result unaffected.
- rst asserted at cycle 10 of a conversion (vin=165.5) -> cmp_clk, busy, done, dac_code, code_out all 0 immediately; next start yields 0xA5.
- start held high, vin changes 165.5->42.5 after the first done -> consecutive code_out values 0xA5 then 0x2A, one IDLE cycle apart.
- SAR_CTRL_MAJ_EN defined, one of the three samples for bit 7 forced wrong -> code_out=0xA5, done 56 cycles after start, 24 cmp_clk pulses.
